upd_phy_llr_feeder: RTL

- Parametrised successor to the slow-PHY-to-LLR unpacker in the uplink receive chain.
- Pops packed IQ words and packed noise words from two first-word-fall-through FIFOs and serialises them into beats of OUT_RE resource elements (REs), each beat carrying one noise sample.
- Adds over the previous generation: generic lane counts, a valid/ready output handshake with backpressure, a per-beat valid mask for the partial last beat, and an explicit start/done framing per user.

---
 rtl/upd_llr_pkg.sv | 29 ++
 rtl/upd_llr_noise_idx.sv | 47 ++++
 rtl/upd_phy_llr_feeder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/upd_llr_pkg.sv
// Shared FSM type, default sizing and width helpers for the uplink LLR feeder.
package upd_llr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT,
        FLUSH
    } llr_state_t;

    localparam int DEF_DW       = 16;
    localparam int DEF_IQ_LANES = 4;
    localparam int DEF_NZ_LANES = 8;
    localparam int DEF_OUT_RE   = 2;
    localparam int DEF_CNT_W    = 16;

    // One complex RE is I in the low half, Q in the high half.
    localparam int DEF_RE_W      = 2 * DEF_DW;
    localparam int DEF_BEAT_W    = DEF_OUT_RE * DEF_RE_W;
    localparam int DEF_IQ_WORD_W = DEF_IQ_LANES * DEF_RE_W;
    localparam int DEF_NZ_WORD_W = DEF_NZ_LANES * DEF_DW;

    localparam int STALL_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upd_llr_noise_idx.sv
// Rate counter and noise lane index; tracks floor(re_k / Ne) within a noise word.
module upd_llr_noise_idx
    import upd_llr_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int STEP     = DEF_OUT_RE,
    parameter int NZ_LANES = DEF_NZ_LANES,
    parameter int NI_W     = idx_w(DEF_NZ_LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] rate,
    output logic [NI_W-1:0]  ni,
    output logic             wrap
);

    logic [CNT_W-1:0] rc;
    logic [CNT_W:0]   rc_sum;
    logic             step_ni;

    // rate >= STEP, so a single subtraction keeps rc = re_k mod rate.
    always_comb begin
        rc_sum  = {1'b0, rc} + (CNT_W+1)'(STEP);
        step_ni = (rc_sum >= {1'b0, rate});
        wrap    = advance && step_ni && (ni == NI_W'(NZ_LANES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc <= '0;
            ni <= '0;
        end else if (clear) begin
            rc <= '0;
            ni <= '0;
        end else if (advance) begin
            if (step_ni) begin
                rc <= CNT_W'(rc_sum - {1'b0, rate});
                ni <= (ni == NI_W'(NZ_LANES - 1)) ? '0 : ni + NI_W'(1);
            end else begin
                rc <= rc_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/upd_phy_llr_feeder.sv
// Unpacks IQ/noise FIFO words into OUT_RE-wide beats with valid/ready handshake.
// Optional stall counter built when UPDLLR_STALL_CNT_EN is defined.
module upd_phy_llr_feeder
    import upd_llr_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int IQ_LANES = DEF_IQ_LANES,
    parameter int NZ_LANES = DEF_NZ_LANES,
    parameter int OUT_RE   = DEF_OUT_RE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                       i_core_clk,
    input  logic                       i_rx_rstn,
    input  logic                       i_start,
    input  logic [CNT_W-1:0]           i_user_iq_noise_rate,
    input  logic [CNT_W-1:0]           i_cur_user_re_amounts,
    input  logic [2*IQ_LANES*DW-1:0]   IQ_Data_SUM,
    input  logic                       IQ_FIFO_Empty,
    output logic                       IQ_FIFO_Read_Enable,
    input  logic [NZ_LANES*DW-1:0]     Noise_Data_SUM,
    input  logic                       Noise_FIFO_Empty,
    output logic                       Noise_FIFO_Read_Enable,
    output logic                       o_data_strobe,
    input  logic                       i_ready,
    output logic [2*OUT_RE*DW-1:0]     o_re_data,
    output logic [OUT_RE-1:0]          o_re_mask,
    output logic [DW-1:0]              o_noise_data,
    output logic                       o_done,
    output logic [STALL_W-1:0]         o_stall_cnt
);

    localparam int RE_W   = 2 * DW;
    localparam int BEAT_W = OUT_RE * RE_W;
    localparam int GROUPS = IQ_LANES / OUT_RE;
    localparam int GRP_W  = idx_w(GROUPS);
    localparam int NI_W   = idx_w(NZ_LANES);

    llr_state_t state, state_nxt;

    logic [CNT_W-1:0]  m_reg;
    logic [CNT_W-1:0]  ne_reg;
    logic [CNT_W-1:0]  ne_in;
    logic [CNT_W-1:0]  re_next;
    logic [CNT_W:0]    re_end;
    logic [GRP_W-1:0]  grp;
    logic              last_loaded;
    logic [NI_W-1:0]   ni;
    logic              nz_wrap;

    logic              start_acc;
    logic              accept;
    logic              want_load;
    logic              fifo_ok;
    logic              do_load;
    logic              final_beat;
    logic              iq_pop;
    logic              nz_pop;
    logic [OUT_RE-1:0] mask_nxt;

    always_comb begin
        start_acc  = (state == IDLE) && i_start;
        accept     = o_data_strobe && i_ready;
        ne_in      = (i_user_iq_noise_rate < CNT_W'(OUT_RE)) ? CNT_W'(OUT_RE)
                                                             : i_user_iq_noise_rate;
        // A beat loads from LOAD, or straight back-to-back in EMIT as the held beat leaves.
        want_load  = (state == LOAD) || ((state == EMIT) && accept && !last_loaded);
        fifo_ok    = !IQ_FIFO_Empty && !Noise_FIFO_Empty;
        do_load    = want_load && fifo_ok;
        re_end     = {1'b0, re_next} + (CNT_W+1)'(OUT_RE);
        final_beat = (re_end >= {1'b0, m_reg});
        iq_pop     = do_load && ((grp == GRP_W'(GROUPS - 1)) || final_beat);
        nz_pop     = do_load && (nz_wrap || final_beat);
        mask_nxt   = '0;
        for (int unsigned j = 0; j < OUT_RE; j++) begin
            mask_nxt[j] = (({1'b0, re_next} + (CNT_W+1)'(j)) < {1'b0, m_reg});
        end
    end

    assign IQ_FIFO_Read_Enable    = iq_pop;
    assign Noise_FIFO_Read_Enable = nz_pop;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start && (i_cur_user_re_amounts != '0)) state_nxt = LOAD;
            end
            LOAD: begin
                if (do_load) state_nxt = EMIT;
            end
            EMIT: begin
                if (accept) begin
                    if (last_loaded)  state_nxt = FLUSH;
                    else if (!do_load) state_nxt = LOAD;
                end
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            m_reg         <= '0;
            ne_reg        <= '0;
            re_next       <= '0;
            grp           <= '0;
            last_loaded   <= 1'b0;
            o_data_strobe <= 1'b0;
            o_re_data     <= '0;
            o_re_mask     <= '0;
            o_noise_data  <= '0;
            o_done        <= 1'b0;
        end else begin
            o_done <= (start_acc && (i_cur_user_re_amounts == '0)) || (state == FLUSH);
            if (start_acc) begin
                m_reg       <= i_cur_user_re_amounts;
                ne_reg      <= ne_in;
                re_next     <= '0;
                grp         <= '0;
                last_loaded <= 1'b0;
            end
            if (do_load) begin
                o_data_strobe <= 1'b1;
                o_re_data     <= IQ_Data_SUM[BEAT_W * int'(grp) +: BEAT_W];
                o_re_mask     <= mask_nxt;
                o_noise_data  <= Noise_Data_SUM[DW * int'(ni) +: DW];
                re_next       <= re_end[CNT_W-1:0];
                grp           <= iq_pop ? '0 : grp + GRP_W'(1);
                last_loaded   <= final_beat;
            end else if (accept) begin
                o_data_strobe <= 1'b0;
            end
        end
    end

    upd_llr_noise_idx #(
        .CNT_W    (CNT_W),
        .STEP     (OUT_RE),
        .NZ_LANES (NZ_LANES),
        .NI_W     (NI_W)
    ) u_noise_idx (
        .clk     (i_core_clk),
        .rst_n   (i_rx_rstn),
        .clear   (start_acc),
        .advance (do_load),
        .rate    (ne_reg),
        .ni      (ni),
        .wrap    (nz_wrap)
    );

`ifdef UPDLLR_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt;

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (want_load && !fifo_ok && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

endmodule
